// File: rtl/pc_fetch.sv
// Program counter and instruction fetch for the single-cycle MIPS core.
// Fetches over a req/ack handshake, holds the instruction through EXEC, then commits next PC.
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        stall,
   input  logic [3:0]  NPCOp,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        misalign
);

   localparam int unsigned XLEN = 32;

   // Next-PC codes shared with ctrl_unit
   localparam logic [3:0] NPC_PLUS4 = 4'd0;
   localparam logic [3:0] NPC_BEQ   = 4'd1;
   localparam logic [3:0] NPC_BNE   = 4'd2;
   localparam logic [3:0] NPC_BLEZ  = 4'd3;
   localparam logic [3:0] NPC_BGTZ  = 4'd4;
   localparam logic [3:0] NPC_BLTZ  = 4'd5;
   localparam logic [3:0] NPC_BGEZ  = 4'd6;
   localparam logic [3:0] NPC_JUMP  = 4'd7;
   localparam logic [3:0] NPC_JUMPR = 4'd8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_EXEC = 2'd2,
      S_HALT = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   instr_q, instr_d;
   logic              instr_valid_q, instr_valid_d;
   logic              imem_req_q, imem_req_d;
   logic              misalign_q, misalign_d;

   logic [XLEN-1:0]   sext_shl;
   logic [XLEN-1:0]   branch_tgt;
   logic [XLEN-1:0]   next_pc;
   logic              rs_neg;
   logic              rs_zero;
   logic              jumpr_bad;

   assign pc_plus4  = pc_q + XLEN'(4);
   assign pc        = pc_q;
   assign imem_addr = pc_q;
   assign instr     = instr_q;
   assign instr_valid = instr_valid_q;
   assign imem_req  = imem_req_q;
   assign misalign  = misalign_q;

   // Target selection from the current instruction and register operands
   always_comb begin
      sext_shl   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      branch_tgt = pc_plus4 + sext_shl;
      rs_neg     = rs_data[XLEN-1];
      rs_zero    = (rs_data == '0);
      jumpr_bad  = (NPCOp == NPC_JUMPR) && (rs_data[1:0] != 2'b00);
      next_pc    = pc_plus4;
      case (NPCOp)
         NPC_PLUS4: next_pc = pc_plus4;
         NPC_BEQ:   if (rs_data == rt_data)  next_pc = branch_tgt;
         NPC_BNE:   if (rs_data != rt_data)  next_pc = branch_tgt;
         NPC_BLEZ:  if (rs_neg || rs_zero)   next_pc = branch_tgt;
         NPC_BGTZ:  if (!rs_neg && !rs_zero) next_pc = branch_tgt;
         NPC_BLTZ:  if (rs_neg)              next_pc = branch_tgt;
         NPC_BGEZ:  if (!rs_neg)             next_pc = branch_tgt;
         NPC_JUMP:  next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
         NPC_JUMPR: next_pc = rs_data;
         default:   next_pc = pc_plus4;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      misalign_d = misalign_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (!stall) begin
               if (jumpr_bad) begin
                  misalign_d = 1'b1;
                  state_d    = S_HALT;
               end else begin
                  pc_d    = next_pc;
                  state_d = S_REQ;
               end
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      // Outputs are registered versions of the upcoming state
      imem_req_d    = (state_d == S_REQ);
      instr_valid_d = (state_d == S_EXEC);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         imem_req_q    <= 1'b0;
         misalign_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         imem_req_q    <= imem_req_d;
         misalign_q    <= misalign_d;
      end
   end

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: expected fetch addresses are queued when an
// instruction is handed over and compared when the DUT issues its next request.
module tb_pc_fetch;

   localparam logic [3:0] NPC_PLUS4 = 4'd0;
   localparam logic [3:0] NPC_BEQ   = 4'd1;
   localparam logic [3:0] NPC_BNE   = 4'd2;
   localparam logic [3:0] NPC_BLEZ  = 4'd3;
   localparam logic [3:0] NPC_BGTZ  = 4'd4;
   localparam logic [3:0] NPC_BLTZ  = 4'd5;
   localparam logic [3:0] NPC_BGEZ  = 4'd6;
   localparam logic [3:0] NPC_JUMP  = 4'd7;
   localparam logic [3:0] NPC_JUMPR = 4'd8;

   localparam logic [31:0] I_ADDI = 32'h2008_0005;
   localparam logic [31:0] I_JR   = 32'h03E0_0008;
   localparam logic [31:0] I_BEQ  = 32'h1000_FFFF;
   localparam logic [31:0] I_BR4  = 32'h0400_0004;
   localparam logic [31:0] I_JAL  = 32'h0C00_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        stall;
   logic [3:0]  NPCOp;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        misalign;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_q[$];

   pc_fetch dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid),
      .stall(stall), .NPCOp(NPCOp),
      .rs_data(rs_data), .rt_data(rt_data),
      .pc(pc), .pc_plus4(pc_plus4), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_npc(input logic [31:0] cur, input logic [31:0] ins,
                                             input logic [3:0] op, input logic [31:0] rs,
                                             input logic [31:0] rt);
      logic [31:0] p4, bt;
      p4 = cur + 32'd4;
      bt = p4 + {{14{ins[15]}}, ins[15:0], 2'b00};
      case (op)
         NPC_BEQ:   return (rs == rt) ? bt : p4;
         NPC_BNE:   return (rs != rt) ? bt : p4;
         NPC_BLEZ:  return ($signed(rs) <= 0) ? bt : p4;
         NPC_BGTZ:  return ($signed(rs) > 0) ? bt : p4;
         NPC_BLTZ:  return ($signed(rs) < 0) ? bt : p4;
         NPC_BGEZ:  return ($signed(rs) >= 0) ? bt : p4;
         NPC_JUMP:  return {p4[31:28], ins[25:0], 2'b00};
         NPC_JUMPR: return rs;
         default:   return p4;
      endcase
   endfunction

   task automatic wait_req(output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 20) begin
         if (imem_req === 1'b1) ok = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
   endtask

   // One fetch/execute transaction with optional memory wait and stall cycles
   task automatic step(input string tag, input logic [31:0] ins, input logic [3:0] op,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input int waits, input int stalls);
      bit ok;
      bit bad;
      logic [31:0] exp_pc, nxt;
      int nvalid;
      wait_req(ok);
      chk({tag, "/req_seen"}, 32'(ok), 32'd1);
      if (!ok) return;
      chk({tag, "/sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() == 0) return;
      exp_pc = exp_q.pop_front();
      chk({tag, "/addr"}, imem_addr, exp_pc);
      for (int w = 0; w < waits; w++) begin
         imem_ack = 1'b0;
         @(negedge clk);
         chk({tag, "/wait_req"}, 32'(imem_req), 32'd1);
         chk({tag, "/wait_addr"}, imem_addr, exp_pc);
      end
      imem_ack   = 1'b1;
      imem_rdata = ins;
      NPCOp      = op;
      rs_data    = rs;
      rt_data    = rt;
      nxt = model_npc(exp_pc, ins, op, rs, rt);
      bad = (op == NPC_JUMPR) && (rs[1:0] != 2'b00);
      if (!bad) exp_q.push_back(nxt);
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      chk({tag, "/valid"}, 32'(instr_valid), 32'd1);
      chk({tag, "/instr"}, instr, ins);
      chk({tag, "/pc"}, pc, exp_pc);
      chk({tag, "/pc_plus4"}, pc_plus4, exp_pc + 32'd4);
      nvalid = 1;
      for (int s = 0; s < stalls; s++) begin
         stall      = 1'b1;
         imem_ack   = 1'b1;
         imem_rdata = 32'hDEAD_BEEF;
         @(negedge clk);
         if (instr_valid === 1'b1) nvalid++;
         chk({tag, "/stall_pc"}, pc, exp_pc);
         chk({tag, "/stall_instr"}, instr, ins);
      end
      stall    = 1'b0;
      imem_ack = 1'b0;
      if (stalls > 0) chk({tag, "/valid_cycles"}, 32'(nvalid), 32'(stalls + 1));
      @(negedge clk);
      chk({tag, "/valid_drop"}, 32'(instr_valid), 32'd0);
      if (bad) begin
         chk({tag, "/misalign"}, 32'(misalign), 32'd1);
         chk({tag, "/pc_held"}, pc, exp_pc);
      end else begin
         chk({tag, "/commit_pc"}, pc, nxt);
      end
   endtask

   task automatic jump_to(input logic [31:0] tgt);
      step("jr_setup", I_JR, NPC_JUMPR, tgt, 32'd0, 0, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  br_op[4];
      logic [31:0] br_rs[2];
      bit ok;
      bit held;
      br_op = '{NPC_BLTZ, NPC_BLEZ, NPC_BGEZ, NPC_BGTZ};
      br_rs = '{32'hFFFF_FFFF, 32'h0000_0000};

      rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
      NPCOp = NPC_PLUS4; rs_data = '0; rt_data = '0;
      repeat (2) @(negedge clk);
      chk("rst/pc", pc, 32'h0);
      chk("rst/instr", instr, 32'h0);
      chk("rst/valid", 32'(instr_valid), 32'd0);
      chk("rst/req", 32'(imem_req), 32'd0);
      chk("rst/misalign", 32'(misalign), 32'd0);
      rst = 1'b0;
      chk("idle/req", 32'(imem_req), 32'd0);
      exp_q.push_back(32'h0);

      step("addi", I_ADDI, NPC_PLUS4, 32'd0, 32'd0, 0, 0);
      jump_to(32'h10);
      step("beq_taken", I_BEQ, NPC_BEQ, 32'd7, 32'd7, 0, 0);
      step("beq_not", I_BEQ, NPC_BEQ, 32'd7, 32'd8, 0, 0);
      step("bne_taken", I_BR4, NPC_BNE, 32'd1, 32'd2, 0, 0);
      foreach (br_rs[r]) begin
         foreach (br_op[b]) begin
            jump_to(32'h20);
            step($sformatf("sbr_%0d_%0d", r, b), I_BR4, br_op[b], br_rs[r], 32'd0, 0, 0);
         end
      end
      jump_to(32'h40);
      step("jal", I_JAL, NPC_JUMP, 32'd0, 32'd0, 0, 0);
      jump_to(32'hFFFF_FFFC);
      step("wrap", I_ADDI, NPC_PLUS4, 32'd0, 32'd0, 0, 0);
      step("undef_op", I_ADDI, 4'hF, 32'd0, 32'd0, 0, 0);
      step("wait_stall", I_ADDI, NPC_PLUS4, 32'd0, 32'd0, 2, 3);

      step("jr_misalign", I_JR, NPC_JUMPR, 32'h1002, 32'd0, 0, 0);
      held = 1'b1;
      imem_ack = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign !== 1'b1) held = 1'b0;
      end
      imem_ack = 1'b0;
      chk("halt/held", 32'(held), 32'd1);
      chk("halt/pc", pc, 32'h8);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst2/misalign", 32'(misalign), 32'd0);
      chk("rst2/pc", pc, 32'h0);
      exp_q.delete();
      exp_q.push_back(32'h0);
      step("resume", I_ADDI, NPC_PLUS4, 32'd0, 32'd0, 0, 0);

      wait_req(ok);
      chk("midreq/seen", 32'(ok), 32'd1);
      chk("midreq/addr", imem_addr, 32'h4);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = 32'h1234_5678;
      chk("midreq/req", 32'(imem_req), 32'd0);
      chk("midreq/pc", pc, 32'h0);
      chk("midreq/valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      imem_ack = 1'b0;
      chk("late_ack/req", 32'(imem_req), 32'd1);
      chk("late_ack/addr", imem_addr, 32'h0);
      chk("late_ack/instr", instr, 32'h0);
      exp_q.delete();
      exp_q.push_back(32'h0);
      step("after_rst", I_ADDI, NPC_PLUS4, 32'd0, 32'd0, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
